// File: rtl/vote_pkg.sv
// Shared constants for the vote button front end: candidate count, default
// debounce length and the debounce counter width helper.
package vote_pkg;

  localparam int NUM_CANDIDATES          = 3;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Counter must hold values 0..cycles-1; one spare code keeps the formula simple.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/vote_debounce_ch.sv
// One button channel: 2-FF synchroniser, stability counter and debounced level.
// rise_req flags an accept of 0->1 on this edge; inhibit_rise cancels it and clears the count.
module vote_debounce_ch
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic inhibit_rise,
  output logic db,
  output logic db_next,
  output logic rise_req
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             db_reg;
  logic             db_next_int;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign rise_req = s2_reg & ~db_reg & (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next    = cnt_reg;
    db_next_int = db_reg;
    if (s2_reg == db_reg) begin
      cnt_next = '0;
    end else if (inhibit_rise && s2_reg) begin
      // Suppressed rise: hold progress at zero so the full count restarts later.
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      db_next_int = s2_reg;
      cnt_next    = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg  <= 1'b0;
      s2_reg  <= 1'b0;
      db_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      s1_reg  <= raw;
      s2_reg  <= s1_reg;
      db_reg  <= db_next_int;
      cnt_reg <= cnt_next;
    end
  end

  assign db      = db_reg;
  assign db_next = db_next_int;

endmodule

// File: rtl/vote_button_conditioner.sv
// Conditions the three candidate vote buttons into clean debounced levels.
// Optional macro VOTE_LOCKOUT_EN adds single-winner lockout and rise arbitration.
module vote_button_conditioner
  import vote_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  input  logic btn3_raw,
  output logic btn1_db,
  output logic btn2_db,
  output logic btn3_db,
  output logic locked
);

  logic [NUM_CANDIDATES-1:0] raw_vec;
  logic [NUM_CANDIDATES-1:0] db_vec;
  logic [NUM_CANDIDATES-1:0] db_next_vec;
  logic [NUM_CANDIDATES-1:0] rise_req_vec;
  logic [NUM_CANDIDATES-1:0] inhibit_vec;

  assign raw_vec = {btn3_raw, btn2_raw, btn1_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_ch
      vote_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .raw          (raw_vec[gi]),
        .inhibit_rise (inhibit_vec[gi]),
        .db           (db_vec[gi]),
        .db_next      (db_next_vec[gi]),
        .rise_req     (rise_req_vec[gi])
      );
    end
  endgenerate

`ifdef VOTE_LOCKOUT_EN
  logic locked_reg;

  // A rise is blocked by any other channel already high or rising on the same edge,
  // so simultaneous rises cancel each other and retry from zero.
  generate
    for (gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_inhibit
      localparam logic [NUM_CANDIDATES-1:0] SELF = NUM_CANDIDATES'(1) << gi;
      assign inhibit_vec[gi] = |((db_vec | rise_req_vec) & ~SELF);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      locked_reg <= 1'b0;
    end else begin
      locked_reg <= |db_next_vec;
    end
  end

  assign locked = locked_reg;
`else
  logic lockout_unused;

  assign inhibit_vec    = '0;
  assign locked         = 1'b0;
  assign lockout_unused = ^{rise_req_vec, db_next_vec};
`endif

  assign btn1_db = db_vec[0];
  assign btn2_db = db_vec[1];
  assign btn3_db = db_vec[2];

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Directed bench for vote_button_conditioner with DEBOUNCE_CYCLES=4.
// Expectations follow the macro VOTE_LOCKOUT_EN when it is defined.
module tb_vote_button_conditioner;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn1_raw = 1'b0;
  logic btn2_raw = 1'b0;
  logic btn3_raw = 1'b0;
  logic btn1_db;
  logic btn2_db;
  logic btn3_db;
  logic locked;

  int tests_run    = 0;
  int tests_failed = 0;

  vote_button_conditioner #(
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn1_raw (btn1_raw),
    .btn2_raw (btn2_raw),
    .btn3_raw (btn3_raw),
    .btn1_db  (btn1_db),
    .btn2_db  (btn2_db),
    .btn3_db  (btn3_db),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    btn1_raw = 1'b1; btn2_raw = 1'b1; btn3_raw = 1'b1;
    tick(2);
    tests_run++;
    if ({btn3_db, btn2_db, btn1_db, locked} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_state: db321,locked=%b%b%b,%b expected 000,0", btn3_db, btn2_db, btn1_db, locked);
    end
    rst = 1'b1;
    tick(DC + 1);
    tests_run++;
    if ({btn3_db, btn2_db, btn1_db} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_early: db321=%b%b%b expected 000", btn3_db, btn2_db, btn1_db);
    end
    tick(1);
    tests_run++;
`ifdef VOTE_LOCKOUT_EN
    // All three rise on the same edge, so arbitration cancels every one.
    if ({btn3_db, btn2_db, btn1_db, locked} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_rise: db321,locked=%b%b%b,%b expected 000,0", btn3_db, btn2_db, btn1_db, locked);
    end
`else
    if ({btn3_db, btn2_db, btn1_db, locked} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL reset_rise: db321,locked=%b%b%b,%b expected 111,0", btn3_db, btn2_db, btn1_db, locked);
    end
`endif
    btn1_raw = 1'b0; btn2_raw = 1'b0; btn3_raw = 1'b0;
    tick(DC + 4);
    tests_run++;
    if ({btn3_db, btn2_db, btn1_db} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_fall: db321=%b%b%b expected 000", btn3_db, btn2_db, btn1_db);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_press_release;
    btn1_raw = 1'b1;
    tick(DC + 1);
    tests_run++;
    if (btn1_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL press_early: btn1_db=%b expected 0", btn1_db);
    end
    tick(1);
    tests_run++;
    if (btn1_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_rise: btn1_db=%b expected 1", btn1_db);
    end
    tick(4);
    btn1_raw = 1'b0;
    tick(DC + 1);
    tests_run++;
    if (btn1_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_early: btn1_db=%b expected 1", btn1_db);
    end
    tick(1);
    tests_run++;
    if (btn1_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_fall: btn1_db=%b expected 0", btn1_db);
    end
    $display("[TB] test_press_release done");
  endtask

  task automatic test_bounce;
    logic [4:0] pattern;
    pattern = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      btn2_raw = pattern[4 - i];
      if (i < 4) tick(1);
    end
    tick(DC + 1);
    tests_run++;
    if (btn2_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_early: btn2_db=%b expected 0", btn2_db);
    end
    tick(1);
    tests_run++;
    if (btn2_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce_rise: btn2_db=%b expected 1", btn2_db);
    end
    btn2_raw = 1'b0;
    tick(DC + 4);
    $display("[TB] test_bounce done");
  endtask

  task automatic test_glitch_and_reset;
    logic seen_high;
    seen_high = 1'b0;
    btn3_raw = 1'b1;
    tick(DC - 1);
    btn3_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (btn3_db !== 1'b0) seen_high = 1'b1;
    end
    tests_run++;
    if (seen_high !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: btn3_db went high=%b expected 0", seen_high);
    end
    // Count reaches 2 after four edges; a one-cycle reset must discard it.
    btn3_raw = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    tests_run++;
    if ({btn3_db, locked} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_state: btn3_db,locked=%b,%b expected 0,0", btn3_db, locked);
    end
    rst = 1'b1;
    tick(DC + 1);
    tests_run++;
    if (btn3_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_early: btn3_db=%b expected 0", btn3_db);
    end
    tick(1);
    tests_run++;
    if (btn3_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_rise: btn3_db=%b expected 1", btn3_db);
    end
    btn3_raw = 1'b0;
    tick(DC + 4);
    $display("[TB] test_glitch_and_reset done");
  endtask

  task automatic test_lockout;
    btn1_raw = 1'b1;
    tick(DC + 2);
    tests_run++;
    if (btn1_db !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_btn1_up: btn1_db=%b expected 1", btn1_db);
    end
    btn3_raw = 1'b1;
`ifdef VOTE_LOCKOUT_EN
    tick(10);
    tests_run++;
    if ({btn3_db, locked} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lock_hold: btn3_db,locked=%b,%b expected 0,1", btn3_db, locked);
    end
    btn1_raw = 1'b0;
    tick(DC + 2);
    tests_run++;
    if ({btn1_db, btn3_db, locked} !== 3'b000) begin
      tests_failed++;
      $display("FAIL lock_release: btn1,btn3,locked=%b%b%b expected 000", btn1_db, btn3_db, locked);
    end
    tick(DC - 1);
    tests_run++;
    if (btn3_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_btn3_early: btn3_db=%b expected 0", btn3_db);
    end
    tick(1);
    tests_run++;
    if ({btn3_db, locked} !== 2'b11) begin
      tests_failed++;
      $display("FAIL lock_btn3_rise: btn3_db,locked=%b,%b expected 1,1", btn3_db, locked);
    end
`else
    tick(DC + 1);
    tests_run++;
    if (btn3_db !== 1'b0) begin
      tests_failed++;
      $display("FAIL nolock_early: btn3_db=%b expected 0", btn3_db);
    end
    tick(1);
    tests_run++;
    if ({btn3_db, btn1_db, locked} !== 3'b110) begin
      tests_failed++;
      $display("FAIL nolock_rise: btn3,btn1,locked=%b%b%b expected 110", btn3_db, btn1_db, locked);
    end
`endif
    btn1_raw = 1'b0; btn3_raw = 1'b0;
    tick(DC + 4);
    tests_run++;
    if ({btn3_db, btn2_db, btn1_db, locked} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL lock_idle: db321,locked=%b%b%b,%b expected 000,0", btn3_db, btn2_db, btn1_db, locked);
    end
    $display("[TB] test_lockout done");
  endtask

  task automatic test_simultaneous;
    btn1_raw = 1'b1; btn2_raw = 1'b1;
`ifdef VOTE_LOCKOUT_EN
    begin
      logic any_high;
      int   waited;
      any_high = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (btn1_db !== 1'b0 || btn2_db !== 1'b0) any_high = 1'b1;
      end
      tests_run++;
      if (any_high !== 1'b0) begin
        tests_failed++;
        $display("FAIL simul_hold: a db rose=%b expected 0", any_high);
      end
      btn2_raw = 1'b0;
      waited = 0;
      while (btn1_db !== 1'b1 && waited < 12) begin
        tick(1);
        waited++;
      end
      tests_run++;
      if ({btn1_db, btn2_db, locked} !== 3'b101) begin
        tests_failed++;
        $display("FAIL simul_retry: btn1,btn2,locked=%b%b%b after %0d cycles expected 101", btn1_db, btn2_db, locked, waited);
      end
    end
`else
    tick(DC + 1);
    tests_run++;
    if ({btn2_db, btn1_db} !== 2'b00) begin
      tests_failed++;
      $display("FAIL simul_early: btn2,btn1=%b%b expected 00", btn2_db, btn1_db);
    end
    tick(1);
    tests_run++;
    if ({btn2_db, btn1_db, locked} !== 3'b110) begin
      tests_failed++;
      $display("FAIL simul_rise: btn2,btn1,locked=%b%b%b expected 110", btn2_db, btn1_db, locked);
    end
`endif
    btn1_raw = 1'b0; btn2_raw = 1'b0;
    tick(DC + 4);
    $display("[TB] test_simultaneous done");
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_press_release();
    test_bounce();
    test_glitch_and_reset();
    test_lockout();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
